// File: rtl/alu_arb_pkg.sv
// Shared constants for the two-requester ALU arbiter: FSM encoding,
// requester IDs and the ALU operation codes.
package alu_arb_pkg;

  localparam int ALU_W  = 8;
  localparam int ALU_SW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  localparam logic [ALU_SW-1:0] ALU_ADD  = 4'h0;
  localparam logic [ALU_SW-1:0] ALU_SUB  = 4'h1;
  localparam logic [ALU_SW-1:0] ALU_AND  = 4'h2;
  localparam logic [ALU_SW-1:0] ALU_OR   = 4'h3;
  localparam logic [ALU_SW-1:0] ALU_XOR  = 4'h4;
  localparam logic [ALU_SW-1:0] ALU_SHL  = 4'h5;
  localparam logic [ALU_SW-1:0] ALU_SHR  = 4'h6;
  localparam logic [ALU_SW-1:0] ALU_PASS = 4'h7;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters. Shifts use the low
// log2(W) bits of B; unassigned op codes produce zero.
module alu
  import alu_arb_pkg::*;
#(
  parameter int W  = 8,
  parameter int SW = 4
) (
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  input  logic [SW-1:0] sel,
  output logic [W-1:0]  out
);

  localparam int SHW = $clog2(W);

  always_comb begin
    out = '0;
    case (sel)
      ALU_ADD:  out = A + B;
      ALU_SUB:  out = A - B;
      ALU_AND:  out = A & B;
      ALU_OR:   out = A | B;
      ALU_XOR:  out = A ^ B;
      ALU_SHL:  out = A << B[SHW-1:0];
      ALU_SHR:  out = A >> B[SHW-1:0];
      ALU_PASS: out = B;
      default:  out = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; captures the
// granted operands, executes for one cycle and holds the result until taken.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int W  = 8,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [W-1:0]  req0_a,
  input  logic [W-1:0]  req0_b,
  input  logic [SW-1:0] req0_sel,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [W-1:0]  req1_a,
  input  logic [W-1:0]  req1_b,
  input  logic [SW-1:0] req1_sel,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_out,
  output logic          res_id,
  output logic          busy,
  output state_t        state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high. Requesters hold payload while valid & !ready; the result port
  // holds payload while res_valid & !res_ready.

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic [W-1:0]  op_a_q, op_a_d;
  logic [W-1:0]  op_b_q, op_b_d;
  logic [SW-1:0] op_sel_q, op_sel_d;
  logic          op_id_q, op_id_d;
  logic          res_valid_q, res_valid_d;
  logic [W-1:0]  res_out_q, res_out_d;
  logic          res_id_q, res_id_d;

  logic          grant0, grant1;
  logic [W-1:0]  alu_out;

  // Operand registers only change on capture, so the ALU inputs naturally
  // hold their last value outside EXEC.
  alu #(.W(W), .SW(SW)) u_alu (
    .A   (op_a_q),
    .B   (op_b_q),
    .sel (op_sel_q),
    .out (alu_out)
  );

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_sel_d    = op_sel_q;
    op_id_d     = op_id_q;
    res_valid_d = res_valid_q;
    res_out_d   = res_out_q;
    res_id_d    = res_id_q;
    grant0      = 1'b0;
    grant1      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        grant0 = req0_valid & (~req1_valid | (prio_q == ID_REQ0));
        grant1 = req1_valid & (~req0_valid | (prio_q == ID_REQ1));
        if (grant0 || grant1) begin
          op_a_d   = grant1 ? req1_a   : req0_a;
          op_b_d   = grant1 ? req1_b   : req0_b;
          op_sel_d = grant1 ? req1_sel : req0_sel;
          op_id_d  = grant1 ? ID_REQ1  : ID_REQ0;
          prio_d   = grant1 ? ID_REQ0  : ID_REQ1;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_out_d   = alu_out;
        res_id_d    = op_id_q;
        res_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prio_q      <= ID_REQ0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sel_q    <= '0;
      op_id_q     <= ID_REQ0;
      res_valid_q <= 1'b0;
      res_out_q   <= '0;
      res_id_q    <= ID_REQ0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_sel_q    <= op_sel_d;
      op_id_q     <= op_id_d;
      res_valid_q <= res_valid_d;
      res_out_q   <= res_out_d;
      res_id_q    <= res_id_d;
    end
  end

  // Ready is masked while reset is asserted so no handshake can appear to
  // complete against registers that are being cleared.
  assign req0_ready = grant0 & ~rst;
  assign req1_ready = grant1 & ~rst;
  assign res_valid  = res_valid_q;
  assign res_out    = res_out_q;
  assign res_id     = res_id_q;
  assign busy       = (state_q != ST_IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: cycle-level reference model with a
// result scoreboard, directed scenarios followed by random traffic.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int W  = 8;
  localparam int SW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [SW-1:0] req0_sel, req1_sel;
  logic          res_valid, res_ready, res_id, busy;
  logic [W-1:0]  res_out;
  state_t        state_dbg;

  alu_arbiter #(.W(W), .SW(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sel   (req0_sel),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sel   (req1_sel),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_out    (res_out),
    .res_id     (res_id),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [W:0] exp_q[$];  // {id, result}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input int a, input int b, input int sel);
    int r;
    case (sel)
      0: r = a + b;
      1: r = a - b + 256;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a * (1 << (b % 8));
      6: r = a / (1 << (b % 8));
      7: r = b;
      default: r = 0;
    endcase
    return W'(r % 256);
  endfunction

  // Reference model: phase 0 = free, 1 = computing, 2 = result offered.
  int   m_phase = 0;
  logic m_prio  = 1'b0;

  always @(negedge clk) begin
    logic g0, g1;
    if (rst) begin
      check("rst_req0_ready", 32'(req0_ready), 0);
      check("rst_req1_ready", 32'(req1_ready), 0);
      check("rst_res_valid",  32'(res_valid),  0);
      check("rst_busy",       32'(busy),       0);
      check("rst_res_out",    32'(res_out),    0);
      check("rst_res_id",     32'(res_id),     0);
      m_phase = 0;
      m_prio  = 1'b0;
      exp_q.delete();
    end else begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (m_phase == 0) begin
        if (req0_valid && req1_valid) begin
          g1 = m_prio;
          g0 = !m_prio;
        end else begin
          g0 = req0_valid;
          g1 = req1_valid;
        end
      end
      check("req0_ready", 32'(req0_ready), 32'(g0));
      check("req1_ready", 32'(req1_ready), 32'(g1));
      check("busy",       32'(busy),       32'(m_phase != 0));
      check("res_valid",  32'(res_valid),  32'(m_phase == 2));
      if (m_phase == 0 && (g0 || g1)) begin
        if (g1) exp_q.push_back({1'b1, ref_alu(int'(req1_a), int'(req1_b), int'(req1_sel))});
        else    exp_q.push_back({1'b0, ref_alu(int'(req0_a), int'(req0_b), int'(req0_sel))});
        m_prio  = !g1;
        m_phase = 1;
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (m_phase == 2 && res_ready) begin
        m_phase = 0;
      end
    end
  end

  // Monitor: pops on every result handshake and checks hold stability.
  logic         hold_flag = 1'b0;
  logic [W-1:0] hold_out;
  logic         hold_id;

  always @(negedge clk) begin
    logic [W:0] e;
    if (rst) begin
      hold_flag = 1'b0;
    end else begin
      if (hold_flag && res_valid) begin
        check("hold_res_out", 32'(res_out), 32'(hold_out));
        check("hold_res_id",  32'(res_id),  32'(hold_id));
      end
      hold_flag = res_valid && !res_ready;
      hold_out  = res_out;
      hold_id   = res_id;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(res_valid), 0);
        end else begin
          e = exp_q.pop_front();
          check("res_id",  32'(res_id),  32'(e[W]));
          check("res_out", 32'(res_out), 32'(e[W-1:0]));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  logic acc0 = 1'b0, acc1 = 1'b0;
  always @(negedge clk) begin
    acc0 = req0_valid && req0_ready && !rst;
    acc1 = req1_valid && req1_ready && !rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_op(output logic [W-1:0] a, output logic [W-1:0] b, output logic [SW-1:0] s);
    a = W'($urandom_range(0, 255));
    b = W'($urandom_range(0, 255));
    s = SW'($urandom_range(0, 15));
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 8'h33; req0_b = 8'h11; req0_sel = ALU_ADD;
    req1_valid = 1'b1; req1_a = 8'h44; req1_b = 8'h22; req1_sel = ALU_SUB;
    res_ready = 1'b1;
    repeat (3) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Single request: 0A + 02.
    req0_a = 8'h0A; req0_b = 8'h02; req0_sel = ALU_ADD; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    waited = 0;
    while (!res_valid && waited < 10) begin
      tick();
      waited++;
    end
    check("single_wait", 32'(res_valid), 1);
    check("single_out",  32'(res_out), 32'h0C);
    check("single_id",   32'(res_id), 0);
    repeat (2) tick();

    // Contention: both continuously valid, strict alternation.
    req0_a = 8'h0A; req0_b = 8'h02; req0_sel = ALU_ADD;
    req1_a = 8'hF6; req1_b = 8'h0A; req1_sel = ALU_SUB;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (13) tick();

    // Back-pressure: consumer stalls for several cycles.
    res_ready = 1'b0;
    repeat (8) tick();
    res_ready = 1'b1;
    repeat (6) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) tick();

    // Reset mid-operation, with prio pointing at req1 beforehand.
    req0_a = 8'h01; req0_b = 8'h01; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    repeat (2) tick();
    req1_a = 8'h55; req1_b = 8'h05; req1_valid = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_valid = 1'b1;
    repeat (8) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) tick();

    // Withdrawn request while the block is holding a result.
    req0_a = 8'h10; req0_b = 8'h20; req0_sel = ALU_OR; req0_valid = 1'b1;
    res_ready = 1'b0;
    tick();
    req0_valid = 1'b0;
    req1_a = 8'hAA; req1_b = 8'h0F; req1_sel = ALU_AND; req1_valid = 1'b1;
    repeat (2) tick();
    req1_valid = 1'b0;
    repeat (3) tick();
    res_ready = 1'b1;
    repeat (4) tick();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if (acc0) begin
        if ($urandom_range(0, 2) == 0) req0_valid = 1'b0;
        else new_op(req0_a, req0_b, req0_sel);
      end else if (req0_valid) begin
        if ($urandom_range(0, 9) == 0) req0_valid = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        new_op(req0_a, req0_b, req0_sel);
        req0_valid = 1'b1;
      end
      if (acc1) begin
        if ($urandom_range(0, 2) == 0) req1_valid = 1'b0;
        else new_op(req1_a, req1_b, req1_sel);
      end else if (req1_valid) begin
        if ($urandom_range(0, 9) == 0) req1_valid = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        new_op(req1_a, req1_b, req1_sel);
        req1_valid = 1'b1;
      end
      res_ready = ($urandom_range(0, 3) != 0);
      if (i == 300) rst = 1'b1;
      if (i == 302) rst = 1'b0;
      tick();
    end

    // Drain.
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      tick();
      waited++;
    end
    repeat (2) tick();
    check("drain_queue_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one combinational 8-bit `alu` instance between two requesters. Each requester presents operands and an operation select through a valid/ready handshake. The block captures the granted request, runs it through the ALU, and returns the registered result with the requester ID on a single result port under valid/ready back-pressure. It sits between the two datapath clients and the ALU and is the only driver of the ALU inputs.

## Interface
- `W`, 8: operand and result width. Must match the `alu` instance.
- `SW`, 4: operation-select width.
- `clk` input, 1: single clock; all state updates on its rising edge.
- `rst` input, 1: reset, asynchronous and active-high.
- `req0_valid` / `req1_valid` input, 1: requester has an operation pending.
- `req0_ready` / `req1_ready` output, 1: request accepted this cycle. At most one is high in any cycle.
- `req0_a`, `req0_b` / `req1_a`, `req1_b` input, W: operands A and B.
- `req0_sel` / `req1_sel` input, SW: ALU operation select. Passed to the ALU unchanged.
- `res_valid` output, 1: result available.
- `res_ready` input, 1: consumer accepts the result.
- `res_out` output, W: registered ALU result.
- `res_id` output, 1: source of the result (0 = req0, 1 = req1).
- `busy` output, 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, HOLD.
- **IDLE**
  - If exactly one `reqN_valid` is high, that requester is granted.
  - If both are high, the requester named by the priority pointer `prio` is granted.
  - `reqN_ready = (state==IDLE) & grant_N`. Ready is combinational from valid and state.
  - On the handshake: capture A, B, sel and the ID into operand registers, flip `prio` to the other requester, then go to EXEC.
  - If no request is valid: stay in IDLE and leave `prio` unchanged.
- **EXEC**
  - ALU inputs are driven from the operand registers; they are held at last value outside EXEC.
  - At the end of the cycle, register the ALU output into `res_out` and the captured ID into `res_id`.
  - Set `res_valid`=1 and go to HOLD.
- **HOLD**
  - `res_valid`, `res_out` and `res_id` stay stable until `res_valid & res_ready`.
  - On that handshake: clear `res_valid` and go to IDLE.
  - No new request is accepted in HOLD.
- **Fairness**
  - After req0 is granted, `prio` = 1, and the reverse after a req1 grant.
  - With both requesters continuously valid, grants alternate strictly: 0, 1, 0, 1, …
- **Requester rule:** operands and sel stay stable while valid is high and ready is low. Dropping valid before ready is legal; that request is simply not taken.
- **Arithmetic:** the block performs none. `res_out` is exactly the `alu` output for the captured operands, W bits, with no carry or flag output.

## Timing
- **Reset values:** state=IDLE, `prio`=0, `res_valid`=0, `res_out`=0, `res_id`=0, `busy`=0, operand registers 0. Ready outputs are therefore 0 unless a valid is asserted in IDLE.
- **Latency:** request handshake in cycle N, EXEC in N+1, `res_valid` high from N+2.
- **Throughput:** one operation per 3 cycles with `res_ready` held high.
  - HOLD→IDLE at edge N+2 when `res_ready` is high.
  - Next grant in cycle N+3.
- **Back-pressure:** with `res_ready` low, HOLD persists indefinitely. Both ready outputs stay 0 throughout.
- **Reset mid-operation** (EXEC or HOLD): the operation is discarded, no result is delivered, and outputs take their reset values asynchronously.
- **Simultaneous events in IDLE:** both valid → `prio` decides. A requester that is not granted sees ready=0 and must keep its request pending.

## Structure
- Package `alu_arb_pkg`:
  - state enum constants `ST_IDLE`=2'd0, `ST_EXEC`=2'd1, `ST_HOLD`=2'd2;
  - ID constants `ID_REQ0`=1'b0, `ID_REQ1`=1'b1;
  - op constants `ALU_ADD`=4'h0, `ALU_SUB`=4'h1 for benches.
- Sub-module: the existing combinational `alu` (ports A, B, sel, out), instantiated once. The arbitration logic stays in this module with no further hierarchy.

## Test plan
- **Reset:** assert `rst` with both valids high → both ready=0, `res_valid`=0, `busy`=0, `res_out`=8'h00.
- **Single request:** req0 A=8'h0A, B=8'h02, sel=`ALU_ADD` → req0_ready for 1 cycle; 2 cycles later `res_valid`=1, `res_out`=8'h0C, `res_id`=0.
- **Contention:** both valid continuously, req0 ADD 8'h0A+8'h02 and req1 SUB 8'hF6−8'h0A, `res_ready`=1 → results in order ID 0 (8'h0C), 1 (8'hEC), 0, 1, with 3-cycle spacing.
- **Back-pressure:** `res_ready`=0 for 5 cycles after `res_valid` → result held stable, no ready to either requester; after `res_ready`=1, the next grant follows 1 cycle later.
- **Reset mid-op:** pulse `rst` during EXEC → no `res_valid` ever seen for that request; after release, the first grant goes to req0.
- **Withdrawn request:** req1 raises valid then drops it while the block is in HOLD → no req1 grant, no req1 result.
